multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 op  input  7  opcode field of the instruction register.
REQ-005 funct3  input  3  funct3 field of the instruction register.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory access complete this cycle.
REQ-009 pcwrite, irwrite, regwrite, memwrite, adrsrc  output  1 each  datapath enables and selects.
REQ-010 resultsrc, alusrca, alusrcb  output  2 each  result mux: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt; A mux: 00 PC, 01 OldPC, 10 rs1; B mux: 00 rs2, 01 ImmExt, 10 constant 4.
REQ-011 immsrc  output  3  immediate-unit format select.
REQ-012 alucontrol  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
REQ-013 state  output  4  current state encoding, for debug.

Function
REQ-014 States SHALL be encoded as FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BRANCH=10, LUI=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-015 immsrc SHALL be decoded from op in every state: 0000011/0010011 -> 000 (I), 0100011 -> 001 (S), 1100011 -> 101 (B), 0110111 -> 010 (U), 1101111 -> 110 (J), any other -> 000.
REQ-016 In FETCH, adrsrc=0, alusrca=00, alusrcb=10, ALU add and resultsrc=10 SHALL be driven.
REQ-016a In FETCH, irwrite and pcwrite SHALL equal mem_ready.
REQ-016b FETCH SHALL remain in FETCH while mem_ready=0 and SHALL go to DECODE when mem_ready=1.
REQ-017 In DECODE, alusrca=01, alusrcb=01 and ALU add SHALL be driven, computing the branch/jump target into ALUOut.
REQ-017a From DECODE, the next state SHALL be: lw/sw -> MEMADR; R (0110011) -> EXECUTER; I (0010011) -> EXECUTEI; jal -> JAL; B -> BRANCH; lui -> LUI; any other opcode -> FETCH, with no register or memory write.
REQ-018 MEMADR SHALL drive alusrca=10, alusrcb=01 and add, then go to MEMREAD if op=lw or to MEMWRITE if op=sw.
REQ-019 MEMREAD SHALL drive adrsrc=1 and resultsrc=00.
REQ-019a MEMREAD SHALL hold until mem_ready=1, then go to MEMWB.
REQ-019b MEMWB SHALL drive resultsrc=01 and regwrite=1, then go to FETCH.
REQ-020 MEMWRITE SHALL drive adrsrc=1, resultsrc=00 and memwrite=1 for every cycle it is held.
REQ-020a MEMWRITE SHALL hold until mem_ready=1, then go to FETCH.
REQ-021 EXECUTER (alusrca=10, alusrcb=00) and EXECUTEI (alusrca=10, alusrcb=01) SHALL use function decode and then go to ALUWB.
REQ-021a ALUWB SHALL drive resultsrc=00 and regwrite=1, then go to FETCH.
REQ-022 Function decode SHALL map funct3 as: 000 -> sub if op[5]&funct7b5, else add; 010 -> slt; 100 -> xor; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-023 JAL SHALL drive alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1 and regwrite=0, then go to ALUWB; in ALUWB this writes rd=PC+4.
REQ-024 BRANCH SHALL drive alusrca=10, alusrcb=00, sub and resultsrc=00.
REQ-024a In BRANCH, pcwrite SHALL be zero when funct3=000, ~zero when funct3=001, and 0 for any other funct3; BRANCH then goes to FETCH.
REQ-025 LUI SHALL drive resultsrc=11 and regwrite=1, then go to FETCH.
REQ-026 Any output not listed for a state SHALL be 0.
REQ-026a Outputs SHALL be combinational from state, op, funct3, funct7b5, zero and mem_ready.
REQ-027 Cycles per instruction with zero memory wait SHALL be: lw 5, sw 4, R/I 4, jal 4, branch 3, lui 3, illegal 2.
REQ-027a Each wait cycle (mem_ready=0) in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle.

Reset
REQ-028 While rst_n=0, state SHALL be FETCH immediately, independent of clk.
REQ-028a While rst_n=0, pcwrite, irwrite, regwrite and memwrite SHALL be 0, even when mem_ready=1.
REQ-029 Reset asserted mid-instruction (e.g. in MEMWRITE) SHALL abort it: memwrite falls in the same cycle and no write-back follows.
REQ-029a After rst_n rises, the first rising edge SHALL evaluate FETCH.

Verification
REQ-030 lw (op=0000011), mem_ready=1 always -> states 0,1,2,3,4,0; immsrc=000 throughout; regwrite=1 only in state 4.
REQ-031 sw with mem_ready low for 3 cycles in MEMWRITE -> memwrite=1 for 4 consecutive cycles, then state 0; immsrc=001.
REQ-032 R-type sub (funct3=000, funct7b5=1) -> alucontrol=001 in EXECUTER.
REQ-032a I-type addi with funct7b5=1 -> alucontrol=000 in EXECUTEI.
REQ-033 beq with zero=1 -> pcwrite=1 in BRANCH, immsrc=101.
REQ-033a bne with zero=1 -> pcwrite=0 in BRANCH.
REQ-034 jal -> states 0,1,9,7,0; immsrc=110; pcwrite=1 in JAL; regwrite=1 in ALUWB.
REQ-034a lui -> states 0,1,11,0; immsrc=010.
REQ-035 rst_n pulsed low mid-MEMWRITE, away from a clock edge -> state=0 and memwrite=0 within the same cycle.
REQ-035a Illegal op 1111111 -> states 0,1,0, with no write enable asserted.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
// Bundles the signals exchanged between the multicycle controller and its
// datapath.
//   Datapath -> controller : op, funct3, funct7b5, zero, mem_ready
//   Controller -> datapath : pcwrite, irwrite, regwrite, memwrite, adrsrc,
//                            resultsrc, alusrca, alusrcb, immsrc, alucontrol,
//                            state (debug)
// master = datapath side, slave = controller side.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pcwrite;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] immsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pcwrite, irwrite, regwrite, memwrite, adrsrc,
               resultsrc, alusrca, alusrcb, immsrc, alucontrol, state
    );

    modport slave (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pcwrite, irwrite, regwrite, memwrite, adrsrc,
               resultsrc, alusrca, alusrcb, immsrc, alucontrol, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Main controller of a multicycle RV32I-subset processor. A 4-bit state
// register walks each instruction through fetch, decode and its execute /
// memory / write-back steps; all datapath controls are combinational from the
// current state and the instruction/status inputs.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (forces FETCH, masks write enables)
//   bus   : multicycle_ctrl_if.slave, instruction fields and status in,
//           datapath enables/selects and debug state out
module multicycle_ctrl (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.slave    bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_LUI      = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [2:0] func_alu;
    logic       branch_pcwrite;
    logic       pcwrite_raw;
    logic       irwrite_raw;
    logic       regwrite_raw;
    logic       memwrite_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Unused encodings 12-15 fall through the default and recover to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_B:         state_d = S_BRANCH;
                    OP_LUI:       state_d = S_LUI;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (bus.op == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BRANCH:   state_d = S_FETCH;
            S_LUI:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Subtract only for R-type (op[5]=1) with funct7b5; I-type addi ignores bit 30.
    always_comb begin
        func_alu = ALU_ADD;
        case (bus.funct3)
            3'b000:  func_alu = (bus.op[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  func_alu = ALU_SLT;
            3'b100:  func_alu = ALU_XOR;
            3'b110:  func_alu = ALU_OR;
            3'b111:  func_alu = ALU_AND;
            default: func_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        branch_pcwrite = 1'b0;
        case (bus.funct3)
            3'b000:  branch_pcwrite = bus.zero;
            3'b001:  branch_pcwrite = ~bus.zero;
            default: branch_pcwrite = 1'b0;
        endcase
    end

    always_comb begin
        bus.immsrc = 3'b000;
        case (bus.op)
            OP_SW:   bus.immsrc = 3'b001;
            OP_B:    bus.immsrc = 3'b101;
            OP_LUI:  bus.immsrc = 3'b010;
            OP_JAL:  bus.immsrc = 3'b110;
            default: bus.immsrc = 3'b000;
        endcase
    end

    always_comb begin
        pcwrite_raw    = 1'b0;
        irwrite_raw    = 1'b0;
        regwrite_raw   = 1'b0;
        memwrite_raw   = 1'b0;
        bus.adrsrc     = 1'b0;
        bus.resultsrc  = 2'b00;
        bus.alusrca    = 2'b00;
        bus.alusrcb    = 2'b00;
        bus.alucontrol = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                bus.alusrcb   = 2'b10;
                bus.resultsrc = 2'b10;
                irwrite_raw   = bus.mem_ready;
                pcwrite_raw   = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b01;
            end
            S_MEMADR: begin
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
            end
            S_MEMREAD: bus.adrsrc = 1'b1;
            S_MEMWB: begin
                bus.resultsrc = 2'b01;
                regwrite_raw  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adrsrc   = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXECUTER: begin
                bus.alusrca    = 2'b10;
                bus.alucontrol = func_alu;
            end
            S_EXECUTEI: begin
                bus.alusrca    = 2'b10;
                bus.alusrcb    = 2'b01;
                bus.alucontrol = func_alu;
            end
            S_ALUWB: regwrite_raw = 1'b1;
            S_JAL: begin
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b10;
                pcwrite_raw = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca    = 2'b10;
                bus.alucontrol = ALU_SUB;
                pcwrite_raw    = branch_pcwrite;
            end
            S_LUI: begin
                bus.resultsrc = 2'b11;
                regwrite_raw  = 1'b1;
            end
            default: ;
        endcase
    end

    // FETCH would otherwise follow mem_ready during reset; masking keeps the
    // architectural state untouched for as long as rst_n is low.
    assign bus.pcwrite  = pcwrite_raw  & rst_n;
    assign bus.irwrite  = irwrite_raw  & rst_n;
    assign bus.regwrite = regwrite_raw & rst_n;
    assign bus.memwrite = memwrite_raw & rst_n;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Directed-vector bench for multicycle_ctrl. Each stimulus step drives the
// inputs for one cycle and queues the hand-derived expected control word; a
// monitor on the falling edge pops and compares it against the DUT outputs.
module tb_multicycle_ctrl;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_ILL = 7'b1111111;

    logic clk;
    logic rst_n;
    multicycle_ctrl_if bus();

    logic [20:0] expQ[$];
    int checks;
    int failures;
    int vecIdx;

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs {state, pcwrite, irwrite, regwrite, memwrite, adrsrc,
    //        resultsrc, alusrca, alusrcb, immsrc, alucontrol}.
    function automatic logic [20:0] e(input logic [3:0] st, input logic pcw, input logic irw,
                                      input logic rw, input logic mw, input logic adr,
                                      input logic [1:0] rs, input logic [1:0] a,
                                      input logic [1:0] b, input logic [2:0] imm,
                                      input logic [2:0] alu);
        return {st, pcw, irw, rw, mw, adr, rs, a, b, imm, alu};
    endfunction

    function automatic logic [20:0] fetchExp(input logic mr, input logic [2:0] imm);
        return e(4'd0, mr, mr, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000);
    endfunction

    function automatic logic [20:0] decodeExp(input logic [2:0] imm);
        return e(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000);
    endfunction

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic z, input logic mr, input logic [20:0] expv);
        @(posedge clk);
        #1;
        bus.op        = op;
        bus.funct3    = f3;
        bus.funct7b5  = f7;
        bus.zero      = z;
        bus.mem_ready = mr;
        expQ.push_back(expv);
    endtask

    task automatic checkOutput(input logic [20:0] expv);
        logic [20:0] act;
        act = {bus.state, bus.pcwrite, bus.irwrite, bus.regwrite, bus.memwrite, bus.adrsrc,
               bus.resultsrc, bus.alusrca, bus.alusrcb, bus.immsrc, bus.alucontrol};
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL vec%0d got state=%0d ctrl=%h expected state=%0d ctrl=%h",
                     vecIdx, act[20:17], act[16:0], expv[20:17], expv[16:0]);
        end
        vecIdx++;
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    typedef struct {
        logic [2:0] f3;
        logic       f7;
        logic [2:0] alu;
    } rcase_t;

    typedef struct {
        logic [2:0] f3;
        logic       z;
        logic       pcw;
    } bcase_t;

    rcase_t rTab[7];
    bcase_t bTab[5];

    initial begin
        checks   = 0;
        failures = 0;
        vecIdx   = 0;
        rTab[0] = '{3'b000, 1'b1, 3'b001};
        rTab[1] = '{3'b000, 1'b0, 3'b000};
        rTab[2] = '{3'b010, 1'b0, 3'b101};
        rTab[3] = '{3'b100, 1'b0, 3'b100};
        rTab[4] = '{3'b110, 1'b0, 3'b011};
        rTab[5] = '{3'b111, 1'b0, 3'b010};
        rTab[6] = '{3'b001, 1'b1, 3'b000};
        bTab[0] = '{3'b000, 1'b1, 1'b1};
        bTab[1] = '{3'b001, 1'b1, 1'b0};
        bTab[2] = '{3'b000, 1'b0, 1'b0};
        bTab[3] = '{3'b001, 1'b0, 1'b1};
        bTab[4] = '{3'b100, 1'b1, 1'b0};

        rst_n = 1'b0;
        bus.op = OP_LW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
        bus.zero = 1'b0; bus.mem_ready = 1'b1;

        // Reset held with mem_ready=1: enables must stay masked.
        applyStimulus(OP_LW, 3'b000, 1'b0, 1'b0, 1'b1, fetchExp(1'b0, 3'b000));
        #6;
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;

        // lw with one fetch wait cycle, then zero-wait memory read.
        applyStimulus(OP_LW, 3'b000, 1'b0, 1'b0, 1'b0, fetchExp(1'b0, 3'b000));
        applyStimulus(OP_LW, 3'b000, 1'b0, 1'b0, 1'b1, fetchExp(1'b1, 3'b000));
        applyStimulus(OP_LW, 3'b000, 1'b0, 1'b0, 1'b1, decodeExp(3'b000));
        applyStimulus(OP_LW, 3'b000, 1'b0, 1'b0, 1'b1,
                      e(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
        applyStimulus(OP_LW, 3'b000, 1'b0, 1'b0, 1'b1,
                      e(4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
        applyStimulus(OP_LW, 3'b000, 1'b0, 1'b0, 1'b1,
                      e(4'd4, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000));

        // sw with three wait cycles in MEMWRITE.
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, fetchExp(1'b1, 3'b001));
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, decodeExp(3'b001));
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0,
                      e(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, (i == 3),
                          e(4'd5, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000));
        end

        // R-type function decode.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(OP_R, rTab[i].f3, rTab[i].f7, 1'b0, 1'b1, fetchExp(1'b1, 3'b000));
            applyStimulus(OP_R, rTab[i].f3, rTab[i].f7, 1'b0, 1'b1, decodeExp(3'b000));
            applyStimulus(OP_R, rTab[i].f3, rTab[i].f7, 1'b0, 1'b1,
                          e(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, rTab[i].alu));
            applyStimulus(OP_R, rTab[i].f3, rTab[i].f7, 1'b0, 1'b1,
                          e(4'd7, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
        end

        // addi with bit 30 set stays an add.
        applyStimulus(OP_I, 3'b000, 1'b1, 1'b0, 1'b1, fetchExp(1'b1, 3'b000));
        applyStimulus(OP_I, 3'b000, 1'b1, 1'b0, 1'b1, decodeExp(3'b000));
        applyStimulus(OP_I, 3'b000, 1'b1, 1'b0, 1'b1,
                      e(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
        applyStimulus(OP_I, 3'b000, 1'b1, 1'b0, 1'b1,
                      e(4'd7, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));

        // Branch condition evaluation.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(OP_B, bTab[i].f3, 1'b0, bTab[i].z, 1'b1, fetchExp(1'b1, 3'b101));
            applyStimulus(OP_B, bTab[i].f3, 1'b0, bTab[i].z, 1'b1, decodeExp(3'b101));
            applyStimulus(OP_B, bTab[i].f3, 1'b0, bTab[i].z, 1'b1,
                          e(4'd10, bTab[i].pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b101, 3'b001));
        end

        // jal.
        applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, fetchExp(1'b1, 3'b110));
        applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, decodeExp(3'b110));
        applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1,
                      e(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b110, 3'b000));
        applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1,
                      e(4'd7, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b110, 3'b000));

        // lui.
        applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, fetchExp(1'b1, 3'b010));
        applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, decodeExp(3'b010));
        applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1,
                      e(4'd11, 0, 0, 1, 0, 0, 2'b11, 2'b00, 2'b00, 3'b010, 3'b000));

        // sw aborted by an asynchronous reset pulse while waiting in MEMWRITE.
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, fetchExp(1'b1, 3'b001));
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, decodeExp(3'b001));
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0,
                      e(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000));
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0,
                      e(4'd5, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        expQ.push_back(fetchExp(1'b0, 3'b001));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;

        // Illegal opcode returns to FETCH after DECODE with no writes.
        applyStimulus(OP_ILL, 3'b000, 1'b0, 1'b0, 1'b0, fetchExp(1'b0, 3'b000));
        applyStimulus(OP_ILL, 3'b000, 1'b0, 1'b0, 1'b1, fetchExp(1'b1, 3'b000));
        applyStimulus(OP_ILL, 3'b000, 1'b0, 1'b0, 1'b1, decodeExp(3'b000));
        applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, fetchExp(1'b0, 3'b010));

        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
